// File: rtl/led_matrix_scan_pkg.sv
// Shared definitions for the 8x8 Game of Life display path.
// Contents:
//   - game state codes, using the same encoding as the core FSM
//   - grid geometry constants
//   - row_select_n: active-low one-hot row drive for a row index
package led_matrix_scan_pkg;

  localparam int GRID_DIM  = 8;
  localparam int GRID_BITS = GRID_DIM * GRID_DIM;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_PROGRAM = 2'b01,
    ST_RUN     = 2'b10,
    ST_PAUSE   = 2'b11
  } game_state_e;

  function automatic logic [GRID_DIM-1:0] row_select_n(input logic [2:0] r);
    return ~(8'b0000_0001 << r);
  endfunction

endpackage

// File: rtl/led_matrix_scan_if.sv
// Bundle between the Game of Life top level and the LED matrix scanner.
// Signals:
//   grid        64  live cell map, bit 8*r+c = row r, column c
//   game_state   2  core state (game_state_e encoding)
//   cursor       6  edit cell index {row[2:0], col[2:0]}
//   row_n        8  row drive, active low
//   col          8  column drive, active high
//   frame_start  1  one-cycle pulse at the start of each frame
// Modports:
//   master  the core side: drives grid/state/cursor, observes the display
//   slave   the scanner: consumes grid/state/cursor, drives the display
interface led_matrix_scan_if;
  import led_matrix_scan_pkg::*;

  logic [GRID_BITS-1:0] grid;
  logic [1:0]           game_state;
  logic [5:0]           cursor;
  logic [GRID_DIM-1:0]  row_n;
  logic [GRID_DIM-1:0]  col;
  logic                 frame_start;

  modport master (
    output grid, game_state, cursor,
    input  row_n, col, frame_start
  );

  modport slave (
    input  grid, game_state, cursor,
    output row_n, col, frame_start
  );

endinterface

// File: rtl/led_matrix_scan_row_timer.sv
// Row scan timing for the LED matrix.
// A dwell counter runs 0..DWELL_CYC-1 for each row; when it wraps, the row
// index advances (7 wraps to 0).
// Ports:
//   clka        in   system clock, rising edge
//   rst         in   asynchronous active-high reset
//   row         out  current row index
//   blank       out  high during the first BLANK_CYC cycles of each row
//   frame_wrap  out  high in the single cycle where row 7 wraps into row 0
module row_timer
  import led_matrix_scan_pkg::*;
#(
  parameter int DWELL_CYC = 1024,
  parameter int BLANK_CYC = 4
) (
  input  logic       clka,
  input  logic       rst,
  output logic [2:0] row,
  output logic       blank,
  output logic       frame_wrap
);

  localparam int CW = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYC - 1);
  localparam logic [CW-1:0] BLANK_LIM  = CW'(BLANK_CYC);

  logic [CW-1:0] dwell_q, dwell_d;
  logic [2:0]    row_q, row_d;
  logic          dwell_wrap;

  // Next-state for the dwell counter and row index; the 3-bit row index
  // wraps from 7 to 0 on its own.
  always_comb begin
    dwell_wrap = (dwell_q == DWELL_LAST);
    dwell_d    = dwell_q + 1'b1;
    row_d      = row_q;
    if (dwell_wrap) begin
      dwell_d = '0;
      row_d   = row_q + 3'd1;
    end
  end

  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      dwell_q <= '0;
      row_q   <= '0;
    end else begin
      dwell_q <= dwell_d;
      row_q   <= row_d;
    end
  end

  assign row        = row_q;
  assign blank      = (dwell_q < BLANK_LIM);
  assign frame_wrap = dwell_wrap && (row_q == 3'd7);

endmodule

// File: rtl/led_matrix_scan.sv
// Display stage for the 8x8 Game of Life core.
// Scans the grid onto a multiplexed LED matrix one row at a time, with a
// blanking gap at the start of each row. The grid and cursor are latched
// once per frame so a generation update mid-frame cannot tear the image.
// In PROGRAM state the cell under the cursor blinks.
// Ports:
//   clka  in   system clock, rising edge
//   rst   in   asynchronous active-high reset
//   bus   slave side of led_matrix_scan_if (grid/game_state/cursor in,
//              row_n/col/frame_start out, all outputs registered)
module led_matrix_scan
  import led_matrix_scan_pkg::*;
#(
  parameter int DWELL_CYC    = 1024,
  parameter int BLANK_CYC    = 4,
  parameter int BLINK_FRAMES = 16
) (
  input  logic               clka,
  input  logic               rst,
  led_matrix_scan_if.slave   bus
);

  localparam int BW = $clog2(BLINK_FRAMES) + 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic [2:0]           row;
  logic                 blank;
  logic                 frame_wrap;

  logic [GRID_BITS-1:0] shadow_q, shadow_d;
  logic [5:0]           cur_q, cur_d;
  logic [BW-1:0]        blink_cnt_q, blink_cnt_d;
  logic                 phase_q, phase_d;
  logic                 prog_q, prog_d;
  logic [GRID_DIM-1:0]  row_n_q, row_n_d;
  logic [GRID_DIM-1:0]  col_q, col_d;
  logic                 frame_start_q, frame_start_d;

  logic                 is_prog;
  logic                 prog_entry;
  logic                 eff_phase;
  logic [GRID_DIM-1:0]  row_data;

  row_timer #(
    .DWELL_CYC (DWELL_CYC),
    .BLANK_CYC (BLANK_CYC)
  ) u_row_timer (
    .clka       (clka),
    .rst        (rst),
    .row        (row),
    .blank      (blank),
    .frame_wrap (frame_wrap)
  );

  // Frame latch, PROGRAM entry detection and blink sequencing.
  // Entry into PROGRAM is found by comparing the live state against last
  // cycle's registered copy. An entry restarts the blink sequence in the
  // lit phase and takes priority over a blink advance on the same edge.
  always_comb begin
    is_prog     = (bus.game_state == ST_PROGRAM);
    prog_entry  = is_prog && !prog_q;
    prog_d      = is_prog;
    shadow_d    = shadow_q;
    cur_d       = cur_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;

    if (frame_wrap) begin
      shadow_d = bus.grid;
      cur_d    = bus.cursor;
    end

    if (prog_entry) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (frame_wrap) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // Output pixel generation for the current row. On the entry cycle the
  // phase register still holds its old value, so the lit phase is used
  // directly to make the cursor appear immediately. The overlay follows the
  // live state, so leaving PROGRAM removes it on the next output cycle.
  always_comb begin
    eff_phase     = prog_entry ? 1'b0 : phase_q;
    row_data      = shadow_q[{row, 3'b000} +: GRID_DIM];
    if (is_prog && (row == cur_q[5:3])) begin
      row_data[cur_q[2:0]] = ~eff_phase;
    end

    row_n_d       = row_select_n(row);
    col_d         = row_data;
    if (blank) begin
      row_n_d = '1;
      col_d   = '0;
    end

    frame_start_d = frame_wrap;
  end

  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      shadow_q      <= '0;
      cur_q         <= '0;
      blink_cnt_q   <= '0;
      phase_q       <= 1'b0;
      prog_q        <= 1'b0;
      row_n_q       <= '1;
      col_q         <= '0;
      frame_start_q <= 1'b0;
    end else begin
      shadow_q      <= shadow_d;
      cur_q         <= cur_d;
      blink_cnt_q   <= blink_cnt_d;
      phase_q       <= phase_d;
      prog_q        <= prog_d;
      row_n_q       <= row_n_d;
      col_q         <= col_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.row_n       = row_n_q;
  assign bus.col         = col_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_led_matrix_scan.sv
// Directed bench for led_matrix_scan with short timing parameters.
// Expected column data for each row of a frame is queued before the frame
// is scanned and popped as each row comes out of the DUT.
module tb_led_matrix_scan;
  import led_matrix_scan_pkg::*;

  localparam int DWELL = 8;
  localparam int BLANK = 2;
  localparam int BLINK = 2;

  localparam logic [63:0] DIAG  = 64'h8040201008040201;
  localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] ZERO  = 64'h0;
  localparam logic [63:0] CUR25 = 64'h0000_0000_0020_0000;
  localparam logic [63:0] CUR63 = 64'h0008_0000_0000_0000;

  logic clka = 1'b0;
  logic rst  = 1'b1;
  int   n_checks = 0;
  int   n_fails  = 0;
  logic [7:0] exp_q[$];

  led_matrix_scan_if u_if ();

  led_matrix_scan #(
    .DWELL_CYC    (DWELL),
    .BLANK_CYC    (BLANK),
    .BLINK_FRAMES (BLINK)
  ) dut (
    .clka (clka),
    .rst  (rst),
    .bus  (u_if.slave)
  );

  always #5 clka = ~clka;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic [63:0] g, input logic [1:0] st, input logic [5:0] cur);
    u_if.grid       = g;
    u_if.game_state = st;
    u_if.cursor     = cur;
  endtask

  task automatic pushFrame(input logic [63:0] cols);
    for (int r = 0; r < 8; r++) exp_q.push_back(cols[8*r +: 8]);
  endtask

  task automatic waitFrameStart(output int cycles);
    cycles = 0;
    do begin
      @(negedge clka);
      cycles++;
    end while (u_if.frame_start !== 1'b1 && cycles < 200);
  endtask

  // Called at the negedge where frame_start is seen; output index i then
  // corresponds to row i/8, dwell i%8. Ends on the next frame_start negedge.
  task automatic checkFrame(input string tag, input int chg_at, input logic [63:0] g,
                            input logic [1:0] st, input logic [5:0] cur);
    logic [7:0] expc;
    logic [7:0] rsel;
    int r;
    int d;
    expc = '0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clka);
      r    = i / 8;
      d    = i % 8;
      rsel = ~(8'b0000_0001 << r);
      if (d == 0) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fails++;
          $error("[TB] FAIL %s scoreboard observed=empty expected=entry", tag);
          expc = '0;
        end else begin
          expc = exp_q.pop_front();
        end
      end
      if (d == 1) checkOutput($sformatf("%s_blank_r%0d", tag, r), {u_if.row_n, u_if.col}, 16'hFF00);
      if (d == 2 || d == 7)
        checkOutput($sformatf("%s_r%0d_d%0d", tag, r, d), {u_if.row_n, u_if.col}, {rsel, expc});
      if (i == 0)  checkOutput({tag, "_fs_low"}, u_if.frame_start, 1'b0);
      if (i == 63) checkOutput({tag, "_fs_period"}, u_if.frame_start, 1'b1);
      if (i == chg_at) applyStimulus(g, st, cur);
    end
  endtask

  initial begin
    int cyc;
    $display("[TB] led_matrix_scan bench start");
    applyStimulus(DIAG, ST_RUN, 6'o00);
    rst = 1'b1;
    repeat (2) @(negedge clka);
    rst = 1'b0;

    // Run into row 2, then hit reset without a clock edge.
    repeat (20) @(negedge clka);
    checkOutput("pre_reset_row_n", u_if.row_n, 8'hFB);
    rst = 1'b1;
    #1;
    checkOutput("reset_row_n", u_if.row_n, 8'hFF);
    checkOutput("reset_col", u_if.col, 8'h00);
    checkOutput("reset_fs", u_if.frame_start, 1'b0);
    @(negedge clka);
    rst = 1'b0;
    waitFrameStart(cyc);
    checkOutput("first_fs_cycles", cyc, 64);

    // Diagonal scan pattern.
    pushFrame(DIAG);
    checkFrame("scan", -1, DIAG, ST_RUN, 6'o00);

    // Grid goes to all ones during row 3; this frame must stay diagonal.
    pushFrame(DIAG);
    checkFrame("tear", 28, ONES, ST_RUN, 6'o00);
    pushFrame(ONES);
    checkFrame("ones", 40, ZERO, ST_RUN, 6'o25);

    // Enter PROGRAM right after the frame boundary.
    pushFrame(ZERO);
    checkFrame("zero", 63, ZERO, ST_PROGRAM, 6'o25);
    pushFrame(CUR25);
    checkFrame("prog_f1", -1, ZERO, ST_PROGRAM, 6'o25);
    pushFrame(CUR25);
    checkFrame("prog_f2", -1, ZERO, ST_PROGRAM, 6'o25);
    pushFrame(ZERO);
    checkFrame("prog_f3", -1, ZERO, ST_PROGRAM, 6'o25);
    pushFrame(ZERO);
    checkFrame("prog_f4", -1, ZERO, ST_PROGRAM, 6'o25);
    pushFrame(CUR25);
    checkFrame("prog_f5", 40, ZERO, ST_RUN, 6'o25);

    // RUN with blink phase 0 still pending: no overlay anywhere.
    pushFrame(ZERO);
    checkFrame("run_a", -1, ZERO, ST_RUN, 6'o25);

    // Blink phase is now 1; re-enter PROGRAM on the boundary cycle.
    pushFrame(ZERO);
    checkFrame("run_b", 62, ZERO, ST_PROGRAM, 6'o25);

    // Entry clear must win: cursor lit; move cursor mid-frame.
    pushFrame(CUR25);
    checkFrame("race", 20, ZERO, ST_PROGRAM, 6'o63);
    pushFrame(CUR63);
    checkFrame("cursor_move", -1, ZERO, ST_PROGRAM, 6'o63);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
